// File: rtl/sdm_xbar_reg_if.sv
// sdm_xbar_reg_if: crossbar data, handshake and connection-request bundle
interface sdm_xbar_reg_if #(parameter int NN = 2, parameter int MN = 3, parameter int DW = 8);
   logic [NN*DW-1:0] in_data;
   logic [NN-1:0]    in_vld;
   logic [NN-1:0]    in_eof;
   logic [NN-1:0]    in_rdy;
   logic [MN*DW-1:0] out_data;
   logic [MN-1:0]    out_vld;
   logic [MN-1:0]    out_eof;
   logic [MN-1:0]    out_rdy;
   logic [MN*NN-1:0] cfg;
   logic [MN-1:0]    lock;
   logic [MN-1:0]    cfg_err;
   modport master (output in_data, in_vld, in_eof, out_rdy, cfg,
                   input in_rdy, out_data, out_vld, out_eof, lock, cfg_err);
   modport slave (input in_data, in_vld, in_eof, out_rdy, cfg,
                  output in_rdy, out_data, out_vld, out_eof, lock, cfg_err);
endinterface

// File: rtl/sdm_xbar_reg.sv
// sdm_xbar_reg: wormhole NN->MN crossbar with per-output locked connection and registered output stage
module sdm_xbar_reg #(parameter int NN = 2, parameter int MN = 3, parameter int DW = 8) (
   input logic clk,
   input logic rst_n,
   sdm_xbar_reg_if.slave x
);
   localparam int SW = NN > 1 ? $clog2(NN) : 1;
   logic [MN-1:0] busy, grant, load, req_err;
   logic [SW-1:0] sel [MN];
   logic [SW-1:0] pick [MN];
   logic [NN-1:0] held, rdy, claim;
   assign x.lock = busy;
   assign x.in_rdy = rdy;
   always_comb begin
      held = '0;
      rdy = '0;
      for (int i = 0; i < MN; i++)
         if (busy[i]) begin
            held[sel[i]] = 1'b1;
            rdy[sel[i]] = rdy[sel[i]] | ~x.out_vld[i] | x.out_rdy[i];
         end
   end
   // lower-indexed idle requesters claim their input first, even if they are themselves rejected
   always_comb begin
      claim = '0;
      grant = '0;
      req_err = '0;
      load = '0;
      for (int i = 0; i < MN; i++) begin
         pick[i] = '0;
         for (int j = 0; j < NN; j++)
            if (x.cfg[i*NN+j]) pick[i] = SW'(j);
         grant[i] = ~busy[i] & $onehot(x.cfg[i*NN +: NN]) & ~held[pick[i]] & ~claim[pick[i]];
         req_err[i] = ~busy[i] & (|x.cfg[i*NN +: NN]) & ~grant[i];
         if (~busy[i] & $onehot(x.cfg[i*NN +: NN])) claim[pick[i]] = 1'b1;
         load[i] = busy[i] & x.in_vld[sel[i]] & (~x.out_vld[i] | x.out_rdy[i]);
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         busy <= '0;
         for (int i = 0; i < MN; i++) sel[i] <= '0;
         x.out_vld <= '0;
         x.out_eof <= '0;
         x.out_data <= '0;
         x.cfg_err <= '0;
      end else begin
         for (int i = 0; i < MN; i++) begin
            if (grant[i]) begin
               busy[i] <= 1'b1;
               sel[i] <= pick[i];
            end else if (load[i] & x.in_eof[sel[i]]) busy[i] <= 1'b0;
            if (load[i]) begin
               x.out_data[i*DW +: DW] <= x.in_data[sel[i]*DW +: DW];
               x.out_eof[i] <= x.in_eof[sel[i]];
               x.out_vld[i] <= 1'b1;
            end else if (x.out_rdy[i]) x.out_vld[i] <= 1'b0;
         end
         x.cfg_err <= req_err;
      end
endmodule
